// File: rtl/memif_pkg.sv
// Shared types for the SPI memory interface and the coefficient write path.
package memif_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH = 36;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 10;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_WORD_WIDTH-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } cws_state_t;

endpackage

// File: rtl/wr_req_fifo.sv
// Circular write-request queue with a commit boundary between the push and pop pointers.
module wr_req_fifo
    import memif_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = wr_req_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   commit,
    input  logic                   pop,
    output logic                   full,
    output logic                   push_accept,
    output logic [$clog2(DEPTH):0] committed_cnt,
    output logic [$clog2(DEPTH):0] uncommitted_cnt,
    output entry_t                 head
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic          pop_ok;
    entry_t        mem [DEPTH];

    assign full            = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign committed_cnt   = commit_ptr - rd_ptr;
    assign uncommitted_cnt = wr_ptr - commit_ptr;
    // A pop can never pass the commit boundary.
    assign pop_ok          = pop && (committed_cnt != '0);
    // A same-cycle pop frees the head slot, so a push into a full queue is still taken.
    assign push_accept     = push && (!full || pop_ok);
    assign wr_ptr_next     = wr_ptr + PW'(push_accept);
    assign head            = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            if (commit) begin
                commit_ptr <= wr_ptr_next;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is not reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr[IW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/coef_write_scheduler.sv
// Holds host coefficient writes until committed, then drains them into the RAM only during DSP idle windows.
module coef_write_scheduler
    import memif_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_wr_valid,
    input  logic [ADDR_WIDTH-1:0]  host_wr_addr,
    input  logic [WORD_WIDTH-1:0]  host_wr_data,
    input  logic                   host_commit,
    input  logic                   dsp_idle,
    output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [WORD_WIDTH-1:0]  mem_wr_data,
    output logic                   mem_wr_enable,
    output logic [$clog2(DEPTH):0] level,
    output logic                   pending,
    output logic                   overflow,
    output logic                   drained
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } req_t;

    cws_state_t state;
    req_t       push_entry;
    req_t       head;
    logic       full;
    logic       push_accept;
    logic       pop;
    logic       pending_next;
    logic [CW-1:0] committed_cnt;
    logic [CW-1:0] uncommitted_cnt;
    logic [CW-1:0] commit_add;
    logic [CW-1:0] committed_next;
    logic [CW-1:0] level_next;

    assign push_entry = '{addr: host_wr_addr, data: host_wr_data};

    wr_req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk             (clk),
        .reset           (reset),
        .push            (host_wr_valid),
        .push_entry      (push_entry),
        .commit          (host_commit),
        .pop             (pop),
        .full            (full),
        .push_accept     (push_accept),
        .committed_cnt   (committed_cnt),
        .uncommitted_cnt (uncommitted_cnt),
        .head            (head)
    );

    // Next-cycle occupancy, accounting for a push, commit and pop landing together.
    assign pop            = (state == DRAIN) && dsp_idle && (committed_cnt != '0);
    assign commit_add     = host_commit ? (uncommitted_cnt + CW'(push_accept)) : '0;
    assign committed_next = committed_cnt - CW'(pop) + commit_add;
    assign level_next     = committed_cnt + uncommitted_cnt + CW'(push_accept) - CW'(pop);
    assign pending_next   = !host_commit && ((uncommitted_cnt + CW'(push_accept)) != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mem_wr_enable <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            level         <= '0;
            pending       <= 1'b0;
            overflow      <= 1'b0;
            drained       <= 1'b0;
        end else begin
            mem_wr_enable <= pop;
            drained       <= pop && (committed_next == '0);
            level         <= level_next;
            pending       <= pending_next;
            if (host_wr_valid && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                mem_wr_addr <= head.addr;
                mem_wr_data <= head.data;
            end
            case (state)
                IDLE: begin
                    if (committed_next != '0) begin
                        state <= dsp_idle ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (dsp_idle) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (committed_next == '0) begin
                        state <= IDLE;
                    end else if (!dsp_idle) begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coef_write_scheduler.sv
// Scoreboard bench for coef_write_scheduler: expected RAM writes are queued at commit time and checked as they appear.
module tb_coef_write_scheduler;

    localparam int unsigned WW    = 36;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_wr_valid = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [WW-1:0] host_wr_data = '0;
    logic          host_commit = 1'b0;
    logic          dsp_idle = 1'b0;
    logic [AW-1:0] mem_wr_addr;
    logic [WW-1:0] mem_wr_data;
    logic          mem_wr_enable;
    logic [CW-1:0] level;
    logic          pending;
    logic          overflow;
    logic          drained;

    coef_write_scheduler #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_wr_valid (host_wr_valid),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_commit   (host_commit),
        .dsp_idle      (dsp_idle),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_enable (mem_wr_enable),
        .level         (level),
        .pending       (pending),
        .overflow      (overflow),
        .drained       (drained)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        int            cyc;
        bit            last;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [WW-1:0] d, input int c, input bit last);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [WW-1:0] d);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic commit();
        host_commit = 1'b1;
        tick();
        host_commit = 1'b0;
    endtask

    task automatic do_reset();
        host_wr_valid = 1'b0;
        host_commit   = 1'b0;
        dsp_idle      = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Every write strobe must match the head of the scoreboard, including the cycle it lands on.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_wr_enable) begin
                    if (sb.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h at cyc %0d, expected no write",
                                 mem_wr_addr, mem_wr_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                        check("wr_data", 64'(mem_wr_data), 64'(e.data));
                        check("wr_cycle", 64'(cyc), 64'(e.cyc));
                        check("wr_drained", 64'(drained), 64'(e.last));
                    end
                end else if (drained) begin
                    tests++;
                    errors++;
                    $display("FAIL drained_no_write: got drained=1 at cyc %0d, expected 0", cyc);
                end
            end
        end
    endtask

    task automatic stimulus();
        int c0;
        int r;

        // Reset values
        reset = 1'b1;
        tick();
        check("rst_enable",   64'(mem_wr_enable), 64'(0));
        check("rst_addr",     64'(mem_wr_addr),   64'(0));
        check("rst_data",     64'(mem_wr_data),   64'(0));
        check("rst_level",    64'(level),         64'(0));
        check("rst_pending",  64'(pending),       64'(0));
        check("rst_overflow", 64'(overflow),      64'(0));
        check("rst_drained",  64'(drained),       64'(0));

        // Uncommitted entries never reach the RAM
        do_reset();
        dsp_idle = 1'b1;
        push(10'h010, 36'h00000000A);
        push(10'h011, 36'h00000000B);
        push(10'h012, 36'h00000000C);
        repeat (20) tick();
        check("nocommit_level",   64'(level),   64'(3));
        check("nocommit_pending", 64'(pending), 64'(1));

        // Commit in IDLE with dsp_idle high: writes at N+2..N+4
        do_reset();
        dsp_idle = 1'b1;
        push(10'h010, 36'h00000000A);
        push(10'h011, 36'h00000000B);
        push(10'h012, 36'h00000000C);
        c0 = cyc;
        expect_wr(10'h010, 36'h00000000A, c0 + 2, 1'b0);
        expect_wr(10'h011, 36'h00000000B, c0 + 3, 1'b0);
        expect_wr(10'h012, 36'h00000000C, c0 + 4, 1'b1);
        commit();
        repeat (8) tick();
        check("batch_level",   64'(level),     64'(0));
        check("batch_pending", 64'(pending),   64'(0));
        check("batch_sb",      64'(sb.size()), 64'(0));

        // Commit while DSP busy; writes start two cycles after the idle rise
        do_reset();
        push(10'h020, 36'h123456789);
        push(10'h021, 36'hFEDCBA987);
        push(10'h022, 36'h000000001);
        commit();
        repeat (4) tick();
        check("wait_level", 64'(level), 64'(3));
        r = cyc;
        dsp_idle = 1'b1;
        expect_wr(10'h020, 36'h123456789, r + 2, 1'b0);
        expect_wr(10'h021, 36'hFEDCBA987, r + 3, 1'b0);
        expect_wr(10'h022, 36'h000000001, r + 4, 1'b1);
        repeat (8) tick();
        check("wait_sb", 64'(sb.size()), 64'(0));

        // Idle window closes mid-batch, remaining writes resume in order
        do_reset();
        dsp_idle = 1'b1;
        push(10'h030, 36'h0000000D0);
        push(10'h031, 36'h0000000D1);
        push(10'h032, 36'h0000000D2);
        push(10'h033, 36'h0000000D3);
        c0 = cyc;
        expect_wr(10'h030, 36'h0000000D0, c0 + 2,  1'b0);
        expect_wr(10'h031, 36'h0000000D1, c0 + 3,  1'b0);
        expect_wr(10'h032, 36'h0000000D2, c0 + 10, 1'b0);
        expect_wr(10'h033, 36'h0000000D3, c0 + 11, 1'b1);
        commit();
        tick();
        tick();
        dsp_idle = 1'b0;
        repeat (3) tick();
        check("pause_level",  64'(level),         64'(2));
        check("pause_enable", 64'(mem_wr_enable), 64'(0));
        tick();
        tick();
        dsp_idle = 1'b1;
        repeat (6) tick();
        check("resume_level", 64'(level),     64'(0));
        check("resume_sb",    64'(sb.size()), 64'(0));

        // Push and commit in the same cycle: the pushed word is part of the batch
        do_reset();
        dsp_idle = 1'b1;
        push(10'h050, 36'h000000050);
        c0 = cyc;
        expect_wr(10'h050, 36'h000000050, c0 + 2, 1'b0);
        expect_wr(10'h051, 36'h000000051, c0 + 3, 1'b1);
        host_commit = 1'b1;
        push(10'h051, 36'h000000051);
        host_commit = 1'b0;
        check("samecyc_pending", 64'(pending), 64'(0));
        repeat (5) tick();
        check("samecyc_sb", 64'(sb.size()), 64'(0));

        // DEPTH+1 pushes: the last is dropped and overflow sticks
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            push(AW'(10'h040 + i), WW'(36'h100 + i));
        end
        check("full_level",    64'(level),    64'(DEPTH));
        check("full_overflow", 64'(overflow), 64'(0));
        push(10'h3FF, 36'hBADBADBAD);
        check("ovf_level",    64'(level),    64'(DEPTH));
        check("ovf_overflow", 64'(overflow), 64'(1));
        repeat (3) tick();
        check("ovf_sticky", 64'(overflow), 64'(1));
        dsp_idle = 1'b1;
        c0 = cyc;
        for (int i = 0; i < int'(DEPTH); i++) begin
            expect_wr(AW'(10'h040 + i), WW'(36'h100 + i), c0 + 2 + i, i == int'(DEPTH) - 1);
        end
        commit();
        repeat (12) tick();
        check("ovf_drain_level", 64'(level),     64'(0));
        check("ovf_still_set",   64'(overflow),  64'(1));
        check("ovf_sb",          64'(sb.size()), 64'(0));

        // Reset mid-DRAIN discards everything
        do_reset();
        dsp_idle = 1'b1;
        push(10'h060, 36'h000000060);
        push(10'h061, 36'h000000061);
        push(10'h062, 36'h000000062);
        push(10'h063, 36'h000000063);
        c0 = cyc;
        expect_wr(10'h060, 36'h000000060, c0 + 2, 1'b0);
        expect_wr(10'h061, 36'h000000061, c0 + 3, 1'b0);
        commit();
        tick();
        tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_enable",  64'(mem_wr_enable), 64'(0));
        check("midrst_level",   64'(level),         64'(0));
        check("midrst_drained", 64'(drained),       64'(0));
        tick();
        reset = 1'b0;
        tick();
        commit();
        repeat (10) tick();
        check("postrst_level",   64'(level),     64'(0));
        check("postrst_pending", 64'(pending),   64'(0));
        check("postrst_sb",      64'(sb.size()), 64'(0));
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/coef_write_scheduler.md
# coef_write_scheduler

Sits between the SPI memory interface's write port and the DSP coefficient RAM write port. Queues host write requests, holds them until the host commits a batch, then applies committed writes one per cycle only while the DSP core reports an idle window. Coefficient updates therefore never land mid-frame, and half-written batches are never visible to the datapath.

## Interface
- WORD_WIDTH, 36, RAM data word width
- ADDR_WIDTH, 10, RAM address width
- DEPTH, 8, queue entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- host_wr_valid  in  1  one-cycle pulse per host write word (memif write enable qualified by dataReady)
- host_wr_addr  in  ADDR_WIDTH  write address, sampled with host_wr_valid
- host_wr_data  in  WORD_WIDTH  write data, sampled with host_wr_valid
- host_commit  in  1  one-cycle pulse; all queued entries, including one pushed this cycle, become committed
- dsp_idle  in  1  level; high while the DSP core is not reading coefficient RAM
- mem_wr_addr  out  ADDR_WIDTH  registered RAM write address
- mem_wr_data  out  WORD_WIDTH  registered RAM write data
- mem_wr_enable  out  1  registered RAM write strobe
- level  out  $clog2(DEPTH)+1  queued entries, committed plus uncommitted
- pending  out  1  uncommitted entries exist
- overflow  out  1  sticky; a push arrived while full
- drained  out  1  one-cycle pulse when the last committed entry is written

## Operation
- Queue: circular storage with three pointers, each $clog2(DEPTH)+1 bits with a wrap bit:
  - wr_ptr: push.
  - commit_ptr: commit boundary.
  - rd_ptr: pop.
- Derived counts: full = (wr_ptr − rd_ptr == DEPTH); committed count = commit_ptr − rd_ptr; uncommitted count = wr_ptr − commit_ptr.
- Push: host_wr_valid && !full stores {addr, data} at wr_ptr and increments wr_ptr.
- Push while full: the word is dropped, overflow is set, and the pointers are unchanged.
- Commit: host_commit sets commit_ptr to the post-push value of wr_ptr. A commit with nothing queued is a no-op.
- FSM states:
  - IDLE: committed count = 0. Go to DRAIN if a commit makes the count >0 and dsp_idle=1; go to WAIT if dsp_idle=0.
  - WAIT: committed >0, dsp_idle=0. Go to DRAIN when dsp_idle=1.
  - DRAIN: each cycle with dsp_idle=1 and committed >0, pop the entry at rd_ptr into the output registers and assert mem_wr_enable the next cycle.
    - dsp_idle falls: go to WAIT. No pop that cycle; the output register already loaded still writes.
    - Committed count reaches 0: go to IDLE and pulse drained on the cycle the final mem_wr_enable is high.
- Pushes, commits and pops may occur in the same cycle. A pop never passes commit_ptr. A push to the slot freed by a same-cycle pop is legal.
- Entries are written in push order. Duplicate addresses are not merged.
- Reset mid-batch discards all entries, committed or not. No partial-write recovery.

## Timing
- Reset values:
  - Pointers 0, state IDLE.
  - mem_wr_enable 0, mem_wr_addr 0, mem_wr_data 0.
  - level 0, pending 0, overflow 0, drained 0.
- Commit latency: host_commit at cycle N with dsp_idle=1 in IDLE gives the first mem_wr_enable at N+2 (state update at N+1, pop into the output register, write strobe at N+2).
- Throughput in DRAIN: one write per clk while dsp_idle=1.
- dsp_idle sampled low at cycle M stops the pop at M. At most one write, registered at M−1, appears at M. The DSP must tolerate one write strobe after deasserting dsp_idle; this is a documented system constraint.
- level, pending and overflow update the cycle after the causing event.
- mem_wr_addr and mem_wr_data hold their last value when mem_wr_enable=0.

## Structure
- Shared package memif_pkg:
  - Default WORD_WIDTH and ADDR_WIDTH.
  - Typedef wr_req_t {addr, data}.
  - State enum cws_state_t {IDLE, WAIT, DRAIN}.
- Sub-module wr_req_fifo:
  - Storage and the three pointers.
  - Exposes full, committed_cnt, uncommitted_cnt and head entry.
- The FSM and output registers stay in coef_write_scheduler.

## Test plan
- Three pushes (0x010/A, 0x011/B, 0x012/C), no commit, dsp_idle=1 for 20 cycles -> no mem_wr_enable, pending=1, level=3.
- Same three pushes then commit at cycle N, dsp_idle=1 -> writes A, B, C to 0x010–0x012 at N+2..N+4, drained at N+4, pending=0, level=0.
- Commit with dsp_idle=0, raise dsp_idle 5 cycles later -> no writes while low; writes start 2 cycles after the rise.
- 4 committed entries, dsp_idle drops after the 2nd write -> at most one more write, then pause; the remaining writes resume in order on re-idle.
- DEPTH+1 pushes without drain -> last word dropped, overflow=1 and stays set, level=DEPTH.
- Reset asserted mid-DRAIN -> mem_wr_enable=0 immediately, level=0; a later commit produces no writes.
